// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg
//   Shared types and constants for the instruction fetch queue.
//   INST_WIDTH / ADDR_WIDTH : widths of one queued instruction and its PC
//   ZERO_INST               : all-zero end-of-program word
//   fq_entry_t              : one queue entry {inst, pc}
package inst_queue_pkg;

  localparam int INST_WIDTH = 32;
  localparam int ADDR_WIDTH = 64;

  localparam logic [INST_WIDTH-1:0] ZERO_INST = '0;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
  } fq_entry_t;

  function automatic fq_entry_t mk_entry(input logic [INST_WIDTH-1:0] inst,
                                         input logic [ADDR_WIDTH-1:0] pc);
    fq_entry_t e;
    e.inst = inst;
    e.pc   = pc;
    return e;
  endfunction

endpackage

// File: rtl/fq_ram_2w1r.sv
// fq_ram_2w1r
//   DEPTH x fq_entry_t storage for the fetch queue.
//   Ports:
//     clk            : write clock
//     we0/addr0/d0   : write port 0 (slot at the write pointer)
//     we1/addr1/d1   : write port 1 (slot after the write pointer)
//     raddr/rdata    : asynchronous read of the head slot
//   The two write addresses are always consecutive slots, so they never collide.
module fq_ram_2w1r
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  fq_entry_t     d0,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  fq_entry_t     d1,
  input  logic [AW-1:0] raddr,
  output fq_entry_t     rdata
);

  fq_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we0) r_mem[addr0] <= d0;
    if (we1) r_mem[addr1] <= d1;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Buffers fetch-bus beats and hands single instructions to the decoder.
//   Each beat carries two instructions; one or both are queued depending on
//   in_addr[2]. A zero instruction reaching the head raises sticky halt.
//   Instruction and PC widths come from inst_queue_pkg.
//   Ports:
//     clk, reset (async assert, active low)
//     in_valid/in_ready/in_data/in_addr : fetch beat input
//     flush                             : drop queued and in-flight instructions
//     out_valid/out_ready/out_inst/out_pc : decoder output
//     halt, addr_err                    : sticky status
//     count                             : occupied entries
//   Optional macro INST_FETCH_QUEUE_STATS_EN adds stat_dispatched / stat_stall.
module inst_fetch_queue
  import inst_queue_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int DEPTH          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BUS_DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0]     in_addr,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INST_WIDTH-1:0]     out_inst,
  output logic [ADDR_WIDTH-1:0]     out_pc,
  output logic                      halt,
  output logic                      addr_err,
  output logic [$clog2(DEPTH):0]    count
`ifdef INST_FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]               stat_dispatched,
  output logic [31:0]               stat_stall
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int CNT_W = AW + 1;
  // in_ready needs room for a full pair, i.e. count <= DEPTH-2
  localparam logic [CNT_W-1:0] PAIR_LIMIT = CNT_W'(DEPTH - 2);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_halt;
  logic             r_addr_err;

  fq_entry_t        w_head;
  fq_entry_t        w_wr0_data;
  fq_entry_t        w_wr1_data;
  logic             w_head_zero;
  logic             w_misaligned;
  logic             w_accept;
  logic             w_push_pair;
  logic             w_push_single;
  logic             w_pop;
  logic [CNT_W-1:0] w_push_n;
  logic [CNT_W-1:0] w_pop_n;
  logic [PTR_W-1:0] w_wr_ptr_plus1;

  // in_ready looks only at registered state so out_ready never feeds it
  assign in_ready      = reset & ~r_halt & (r_count <= PAIR_LIMIT);
  assign w_misaligned  = (in_addr[1:0] != 2'b00);
  assign w_accept      = in_valid & in_ready & ~flush;
  assign w_push_pair   = w_accept & ~w_misaligned & ~in_addr[2];
  assign w_push_single = w_accept & ~w_misaligned &  in_addr[2];

  // Pair: low half at in_addr, high half at in_addr+4.
  // Single (upper-slot beat): only the high half is live, at in_addr.
  assign w_wr_ptr_plus1 = r_wr_ptr + PTR_W'(1);
  assign w_wr0_data = mk_entry(w_push_single ? in_data[2*INST_WIDTH-1:INST_WIDTH]
                                             : in_data[INST_WIDTH-1:0],
                               in_addr);
  assign w_wr1_data = mk_entry(in_data[2*INST_WIDTH-1:INST_WIDTH],
                               in_addr + ADDR_WIDTH'(4));

  fq_ram_2w1r #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we0   (w_push_pair | w_push_single),
    .addr0 (r_wr_ptr[AW-1:0]),
    .d0    (w_wr0_data),
    .we1   (w_push_pair),
    .addr1 (w_wr_ptr_plus1[AW-1:0]),
    .d1    (w_wr1_data),
    .raddr (r_rd_ptr[AW-1:0]),
    .rdata (w_head)
  );

  assign w_head_zero = (w_head.inst == ZERO_INST);
  assign out_valid   = (r_count != '0) & ~r_halt & ~w_head_zero;
  assign out_inst    = w_head.inst;
  assign out_pc      = w_head.pc;
  assign w_pop       = out_valid & out_ready;

  // {pair, single} is one-hot or zero, so it reads directly as 2 / 1 / 0
  assign w_push_n = {{(CNT_W-2){1'b0}}, w_push_pair, w_push_single};
  assign w_pop_n  = {{(CNT_W-1){1'b0}}, w_pop};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_halt     <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      if (flush) begin
        // a pop in this cycle was already sampled by the decoder; the
        // reset of the pointers discards everything else
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        r_wr_ptr <= r_wr_ptr + w_push_n;
        r_rd_ptr <= r_rd_ptr + w_pop_n;
        r_count  <= r_count + w_push_n - w_pop_n;
      end
      if ((r_count != '0) && w_head_zero) r_halt <= 1'b1;
      if (w_accept && w_misaligned)       r_addr_err <= 1'b1;
    end
  end

  assign halt     = r_halt;
  assign addr_err = r_addr_err;
  assign count    = r_count;

`ifdef INST_FETCH_QUEUE_STATS_EN
  logic [31:0] r_stat_dispatched;
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_dispatched <= '0;
      r_stat_stall      <= '0;
    end else begin
      if (w_pop && (r_stat_dispatched != '1))
        r_stat_dispatched <= r_stat_dispatched + 32'd1;
      if (in_valid && !in_ready && (r_stat_stall != '1))
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_dispatched = r_stat_dispatched;
  assign stat_stall      = r_stat_stall;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] in_addr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        halt;
  logic        addr_err;
  logic [3:0]  count;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  logic m_halt = 1'b0;
  logic m_aerr = 1'b0;

  inst_fetch_queue #(
    .BUS_DATA_WIDTH (64),
    .DEPTH          (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .halt      (halt),
    .addr_err  (addr_err),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, check/score at the negedge,
  // advance the model for the coming edge, then move to posedge+1.
  task automatic cyc(input logic v, input logic [63:0] d, input logic [63:0] a,
                     input logic f, input logic r);
    logic exp_ir;
    logic exp_ov;
    logic next_halt;
    exp_t e;
    in_valid  = v;
    in_data   = d;
    in_addr   = a;
    flush     = f;
    out_ready = r;
    #4;
    exp_ir    = !m_halt && (sb.size() <= 6);
    exp_ov    = (sb.size() != 0) && !m_halt && (sb[0].inst != 32'h0);
    next_halt = (sb.size() != 0) && (sb[0].inst == 32'h0);
    check("in_ready", 64'(in_ready), 64'(exp_ir));
    check("out_valid", 64'(out_valid), 64'(exp_ov));
    check("count", 64'(count), 64'(sb.size()));
    check("halt", 64'(halt), 64'(m_halt));
    check("addr_err", 64'(addr_err), 64'(m_aerr));
    if (exp_ov && r) begin
      e = sb.pop_front();
      check("out_inst", 64'(out_inst), 64'(e.inst));
      check("out_pc", out_pc, e.pc);
      $display("POP inst=%h pc=%h", out_inst, out_pc);
    end
    if (f) begin
      sb.delete();
    end else if (v && exp_ir) begin
      if (a[1:0] != 2'b00) begin
        m_aerr = 1'b1;
      end else if (!a[2]) begin
        sb.push_back('{inst: d[31:0],  pc: a});
        sb.push_back('{inst: d[63:32], pc: a + 64'd4});
      end else begin
        sb.push_back('{inst: d[63:32], pc: a});
      end
    end
    m_halt = m_halt | next_halt;
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges: every output must drop immediately.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_halt", 64'(halt), 64'd0);
    check("rst_addr_err", 64'(addr_err), 64'd0);
    sb.delete();
    m_halt = 1'b0;
    m_aerr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0 && !m_halt; i++)
      cyc(1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] d;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_addr   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #2;
    do_reset();

    // pair beat: two entries, drained in order
    cyc(1'b1, 64'h00A00093_00500113, 64'h1000, 1'b0, 1'b0);
    cyc(1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
    cyc(1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
    cyc(1'b0, 64'h0, 64'h0, 1'b0, 1'b1);

    // upper-slot beat: only the high half is queued
    cyc(1'b1, 64'hDEADBEEF_00000013, 64'h2004, 1'b0, 1'b1);
    cyc(1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
    cyc(1'b0, 64'h0, 64'h0, 1'b0, 1'b1);

    // fill to DEPTH, a fifth beat is held off, pop two, then it goes in
    for (int i = 0; i < 4; i++)
      cyc(1'b1, {32'h1100_0000 + 32'(i), 32'h2200_0000 + 32'(i)}, 64'h4000 + 64'(8 * i), 1'b0, 1'b0);
    cyc(1'b1, 64'h33333333_44444444, 64'h4020, 1'b0, 1'b0);
    cyc(1'b1, 64'h33333333_44444444, 64'h4020, 1'b0, 1'b1);
    cyc(1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
    cyc(1'b1, 64'h33333333_44444444, 64'h4020, 1'b0, 1'b0);
    drain();

    // three entries, then flush together with a beat and a pop
    cyc(1'b1, 64'h55555555_66666666, 64'h5000, 1'b0, 1'b0);
    cyc(1'b1, 64'h77777777_88888888, 64'h500C, 1'b0, 1'b0);
    cyc(1'b1, 64'h99999999_AAAAAAAA, 64'h6000, 1'b1, 1'b1);
    cyc(1'b0, 64'h0, 64'h0, 1'b0, 1'b1);

    // random traffic with occasional flush
    for (int i = 0; i < 300; i++) begin
      a = {$urandom, $urandom};
      a[1:0] = 2'b00;
      d = {$urandom | 32'h1, $urandom | 32'h1};
      cyc(($urandom % 3) != 0, d, a, ($urandom % 20) == 0, $urandom % 2 == 1);
    end
    drain();
    cyc(1'b0, 64'h0, 64'h0, 1'b0, 1'b1);

    // zero instruction at head: halt, then everything stalls until reset
    cyc(1'b1, 64'h12345678_00000000, 64'h3000, 1'b0, 1'b1);
    cyc(1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
    cyc(1'b1, 64'h0BADF00D_0BADF00D, 64'h3100, 1'b0, 1'b1);
    cyc(1'b0, 64'h0, 64'h0, 1'b1, 1'b1);
    cyc(1'b1, 64'h0BADF00D_0BADF00D, 64'h3100, 1'b0, 1'b1);
    do_reset();

    // misaligned beat, then a reset in the middle of traffic
    cyc(1'b1, 64'h11111111_22222222, 64'h1002, 1'b0, 1'b0);
    cyc(1'b1, 64'hCAFEF00D_ABCDEF01, 64'h7000, 1'b0, 1'b0);
    cyc(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    do_reset();
    cyc(1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
    cyc(1'b1, 64'h13131313_24242424, 64'h8008, 1'b0, 1'b1);
    drain();
    cyc(1'b0, 64'h0, 64'h0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
